// File: rtl/sa2_conv_host.sv
// Host-side driver for the 2x2 systolic convolution array. It loads 25 operand
// bytes, runs the array under a watchdog, then streams the four result bytes out.
module sa2_conv_host #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         s_valid,
    input  logic [7:0]   s_data,
    output logic         s_ready,
    output logic         sa_active,
    output logic [127:0] sa_a,
    output logic [71:0]  sa_b,
    input  logic         sa_done,
    input  logic [31:0]  sa_c,
    output logic         m_valid,
    output logic [7:0]   m_data,
    output logic         m_last,
    input  logic         m_ready,
    output logic         busy,
    output logic         timeout_err
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [4:0]      ld_cnt_q, ld_cnt_d;
    logic [1:0]      rd_idx_q, rd_idx_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic [31:0]     res_q, res_d;
    logic [127:0]    sa_a_q, sa_a_d;
    logic [71:0]     sa_b_q, sa_b_d;
    logic            to_q, to_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            ld_cnt_q <= '0;
            rd_idx_q <= '0;
            wd_q     <= '0;
            res_q    <= '0;
            sa_a_q   <= '0;
            sa_b_q   <= '0;
            to_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            ld_cnt_q <= ld_cnt_d;
            rd_idx_q <= rd_idx_d;
            wd_q     <= wd_d;
            res_q    <= res_d;
            sa_a_q   <= sa_a_d;
            sa_b_q   <= sa_b_d;
            to_q     <= to_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ld_cnt_d = ld_cnt_q;
        rd_idx_d = rd_idx_q;
        wd_d     = wd_q;
        res_d    = res_q;
        sa_a_d   = sa_a_q;
        sa_b_d   = sa_b_q;
        to_d     = to_q;
        unique case (state_q)
            IDLE: state_d = LOAD;
            LOAD: begin
                if (s_valid) begin
                    // Slots 16..24 share the low four counter bits with filter index 0..8
                    if (ld_cnt_q[4])
                        sa_b_d[{ld_cnt_q[3:0], 3'b000} +: 8] = s_data;
                    else
                        sa_a_d[{ld_cnt_q[3:0], 3'b000} +: 8] = s_data;
                    if (ld_cnt_q == 5'd24) begin
                        ld_cnt_d = '0;
                        wd_d     = '0;
                        state_d  = RUN;
                    end else begin
                        ld_cnt_d = ld_cnt_q + 5'd1;
                    end
                end
            end
            RUN: begin
                wd_d = wd_q + WD_W'(1);
                // Done takes priority over a simultaneous watchdog expiry
                if (sa_done) begin
                    res_d   = sa_c;
                    state_d = DRAIN;
                end else if (wd_q == WD_LAST) begin
                    res_d   = '0;
                    to_d    = 1'b1;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (m_ready) begin
                    if (rd_idx_q == 2'd3) begin
                        rd_idx_d = '0;
                        state_d  = LOAD;
                    end else begin
                        rd_idx_d = rd_idx_q + 2'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign s_ready     = (state_q == LOAD);
    assign sa_active   = (state_q == RUN);
    assign m_valid     = (state_q == DRAIN);
    assign busy        = (state_q == RUN) || (state_q == DRAIN);
    assign m_data      = res_q[{rd_idx_q, 3'b000} +: 8];
    assign m_last      = (state_q == DRAIN) && (rd_idx_q == 2'd3);
    assign sa_a        = sa_a_q;
    assign sa_b        = sa_b_q;
    assign timeout_err = to_q;

endmodule

// File: tb/tb_sa2_conv_host.sv
// Directed bench for sa2_conv_host: load, normal run, backpressure, done/expiry
// tie, watchdog timeout and reset during RUN.
module tb_sa2_conv_host;

    logic         clk = 1'b0;
    logic         rst;
    logic         s_valid;
    logic [7:0]   s_data;
    logic         s_ready;
    logic         sa_active;
    logic [127:0] sa_a;
    logic [71:0]  sa_b;
    logic         sa_done;
    logic [31:0]  sa_c;
    logic         m_valid;
    logic [7:0]   m_data;
    logic         m_last;
    logic         m_ready;
    logic         busy;
    logic         timeout_err;

    int nerr = 0;
    int nchk = 0;

    sa2_conv_host #(.TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .sa_active(sa_active), .sa_a(sa_a), .sa_b(sa_b),
        .sa_done(sa_done), .sa_c(sa_c),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_ready"}, s_ready, 1'b0);
        check({tag, "_sa_active"}, sa_active, 1'b0);
        check({tag, "_sa_a"}, sa_a, 128'd0);
        check({tag, "_sa_b"}, sa_b, 72'd0);
        check({tag, "_m_valid"}, m_valid, 1'b0);
        check({tag, "_m_data"}, m_data, 8'd0);
        check({tag, "_m_last"}, m_last, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_timeout_err"}, timeout_err, 1'b0);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!s_ready && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check("wait_s_ready", s_ready, 1'b1);
    endtask

    // Feeds bytes base..base+24; returns at #1 after the edge of the last handshake.
    task automatic load_job(input int base, input bit gap);
        int i = 0;
        int cyc = 0;
        bit gap_done = 1'b0;
        logic [127:0] exp_a;
        logic [71:0]  exp_b;
        while (i < 25 && cyc < 200) begin
            if (gap && !gap_done && i == 8) begin
                s_valid = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                gap_done = 1'b1;
            end
            s_valid = 1'b1;
            s_data  = 8'(base + i);
            if (s_ready) i++;
            @(posedge clk); #1;
            cyc++;
        end
        s_valid = 1'b0;
        check("load_count", i, 25);
        for (int k = 0; k < 16; k++) exp_a[8*k +: 8] = 8'(base + k);
        for (int k = 0; k < 9; k++)  exp_b[8*k +: 8] = 8'(base + 16 + k);
        check("load_sa_a", sa_a, exp_a);
        check("load_sa_b", sa_b, exp_b);
        check("load_sa_active", sa_active, 1'b1);
        check("load_s_ready_low", s_ready, 1'b0);
        check("load_busy", busy, 1'b1);
    endtask

    // Array model: sa_done sampled high on the dly-th edge after sa_active rose.
    task automatic run_array(input int dly, input logic [31:0] c);
        repeat (dly - 1) @(posedge clk);
        #1;
        check("run_still_active", sa_active, 1'b1);
        sa_done = 1'b1;
        sa_c    = c;
        @(posedge clk); #1;
        sa_done = 1'b0;
        sa_c    = 32'hDEADBEEF;
        check("done_sa_active", sa_active, 1'b0);
        check("done_m_valid", m_valid, 1'b1);
    endtask

    task automatic drain(input logic [31:0] c, input bit bp);
        int idx = 0;
        int cyc = 0;
        while (idx < 4 && cyc < 40) begin
            m_ready = bp ? cyc[0] : 1'b1;
            check("drain_m_valid", m_valid, 1'b1);
            check("drain_m_data", m_data, c[8*idx +: 8]);
            check("drain_m_last", m_last, (idx == 3));
            @(posedge clk); #1;
            if (m_ready) idx++;
            cyc++;
        end
        m_ready = 1'b1;
        check("drain_count", idx, 4);
        check("drain_m_valid_low", m_valid, 1'b0);
        check("drain_s_ready", s_ready, 1'b1);
        check("drain_busy", busy, 1'b0);
    endtask

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = 8'd0;
        sa_done = 1'b0; sa_c = 32'd0; m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        check("idle_s_ready", s_ready, 1'b0);
        @(posedge clk); #1;
        check("first_edge_s_ready", s_ready, 1'b1);

        // Job 1: bytes 1..25, done 28 cycles after activate
        load_job(1, 1'b0);
        check("job1_a_lo", sa_a[7:0], 8'd1);
        check("job1_a_hi", sa_a[127:120], 8'd16);
        check("job1_b_lo", sa_b[7:0], 8'd17);
        check("job1_b_hi", sa_b[71:64], 8'd25);
        run_array(28, 32'h44332211);
        drain(32'h44332211, 1'b0);
        check("job1_timeout_err", timeout_err, 1'b0);
        check("job1_a_held", sa_a[7:0], 8'd1);

        // Job 2: input gap and output backpressure
        load_job(40, 1'b1);
        run_array(5, 32'h44332211);
        drain(32'h44332211, 1'b1);

        // Job 3: done on the same edge as watchdog expiry, done wins
        load_job(100, 1'b0);
        run_array(64, 32'hA5C3_7E01);
        check("tie_timeout_err", timeout_err, 1'b0);
        drain(32'hA5C3_7E01, 1'b0);

        // Job 4: array never answers
        load_job(150, 1'b0);
        repeat (63) @(posedge clk);
        #1;
        check("to_before_active", sa_active, 1'b1);
        check("to_before_err", timeout_err, 1'b0);
        @(posedge clk); #1;
        check("to_sa_active", sa_active, 1'b0);
        check("to_m_valid", m_valid, 1'b1);
        check("to_err", timeout_err, 1'b1);
        drain(32'h0, 1'b0);

        // Job 5: normal job after timeout keeps the sticky flag
        load_job(200, 1'b0);
        run_array(10, 32'h1234_5678);
        drain(32'h1234_5678, 1'b0);
        check("sticky_timeout_err", timeout_err, 1'b1);

        // Job 6: reset 10 cycles into RUN
        load_job(7, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_run");
        @(posedge clk); #1;
        rst = 1'b0;
        wait_ready();
        load_job(60, 1'b0);
        run_array(20, 32'hCAFE_F00D);
        drain(32'hCAFE_F00D, 1'b0);
        check("post_rst_timeout_err", timeout_err, 1'b0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
